// File: rtl/ad9634_cfg_sequencer.sv
// Power-up register sequencer for the AD9634 ADC: walks a constant address/data table
// through an external SPI engine, optionally reading back each register, with retry and timeout.
module ad9634_cfg_sequencer #(
  parameter int unsigned NUM_REGS     = 8,
  parameter int unsigned VERIFY       = 1,
  parameter int unsigned SEND_HOLD    = 4,
  parameter int unsigned TIMEOUT_CLKS = 4096,
  parameter int unsigned MAX_RETRY    = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        spi_busy_i,
  input  logic [15:0] spi_dout_i,
  output logic [7:0]  spi_addr_o,
  output logic [15:0] spi_commd_o,
  output logic        spi_send_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [3:0]  err_idx_o,
  output logic [15:0] err_data_o
);

  localparam int unsigned TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam int unsigned CW = (SEND_HOLD > 1) ? $clog2(SEND_HOLD) : 1;
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned IW = 4;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SEND, S_WAIT_RISE, S_WAIT_FALL, S_CHECK, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t          state;
  logic [IW-1:0]   index;
  logic [RW-1:0]   retry;
  logic [TW-1:0]   tmo;
  logic [CW-1:0]   send_cnt;
  logic            phase_rd;
  logic            seen_rise;
  logic [22:0]     entry;
  logic            fail_c;

  // Configuration table: {7-bit register address, 16-bit value}
  function automatic logic [22:0] tbl_entry(input logic [IW-1:0] i);
    case (i)
      4'd0:    tbl_entry = {7'h08, 16'h0000};
      4'd1:    tbl_entry = {7'h0D, 16'h0000};
      4'd2:    tbl_entry = {7'h14, 16'h0001};
      4'd3:    tbl_entry = {7'h15, 16'h0000};
      4'd4:    tbl_entry = {7'h16, 16'h0000};
      4'd5:    tbl_entry = {7'h17, 16'h0000};
      4'd6:    tbl_entry = {7'h18, 16'h0004};
      4'd7:    tbl_entry = {7'h30, 16'h0000};
      default: tbl_entry = 23'h0;
    endcase
  endfunction

  // Any condition that consumes a retry: busy never rose, never fell, or read-back mismatch
  always_comb begin
    entry  = tbl_entry(index);
    fail_c = 1'b0;
    case (state)
      S_WAIT_RISE: fail_c = !spi_busy_i && !seen_rise && (tmo == TW'(TIMEOUT_CLKS - 1));
      S_WAIT_FALL: fail_c = spi_busy_i && (tmo == TW'(TIMEOUT_CLKS - 1));
      S_CHECK:     fail_c = phase_rd && (spi_dout_i != entry[15:0]);
      default:     fail_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= S_IDLE;
      index       <= '0;
      retry       <= '0;
      tmo         <= '0;
      send_cnt    <= '0;
      phase_rd    <= 1'b0;
      seen_rise   <= 1'b0;
      spi_addr_o  <= '0;
      spi_commd_o <= '0;
      spi_send_o  <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      err_idx_o   <= '0;
      err_data_o  <= '0;
    end else if (fail_c) begin
      if (state == S_CHECK) err_data_o <= spi_dout_i;
      if (retry < RW'(MAX_RETRY)) begin
        retry    <= retry + 1'b1;
        phase_rd <= 1'b0;
        state    <= S_LOAD;
      end else begin
        err_idx_o <= index;
        err_o     <= 1'b1;
        busy_o    <= 1'b0;
        state     <= S_ERR;
      end
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            err_idx_o  <= '0;
            err_data_o <= '0;
            index      <= '0;
            retry      <= '0;
            phase_rd   <= 1'b0;
            busy_o     <= 1'b1;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          spi_addr_o  <= {~phase_rd, entry[22:16]};
          spi_commd_o <= phase_rd ? 16'h0000 : entry[15:0];
          spi_send_o  <= 1'b1;
          send_cnt    <= '0;
          seen_rise   <= 1'b0;
          state       <= S_SEND;
        end
        S_SEND: begin
          // A fast engine may raise and even drop busy while send is still held
          if (spi_busy_i) seen_rise <= 1'b1;
          if (send_cnt == CW'(SEND_HOLD - 1)) begin
            spi_send_o <= 1'b0;
            tmo        <= '0;
            state      <= S_WAIT_RISE;
          end else begin
            send_cnt <= send_cnt + 1'b1;
          end
        end
        S_WAIT_RISE: begin
          if (spi_busy_i || seen_rise) begin
            tmo   <= '0;
            state <= S_WAIT_FALL;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        S_WAIT_FALL: begin
          if (!spi_busy_i) state <= S_CHECK;
          else             tmo   <= tmo + 1'b1;
        end
        S_CHECK: begin
          if (phase_rd) begin
            err_data_o <= spi_dout_i;
            state      <= S_NEXT;
          end else if (VERIFY != 0) begin
            phase_rd <= 1'b1;
            state    <= S_LOAD;
          end else begin
            state <= S_NEXT;
          end
        end
        S_NEXT: begin
          retry    <= '0;
          phase_rd <= 1'b0;
          if (index == IW'(NUM_REGS - 1)) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= S_DONE;
          end else begin
            index <= index + 1'b1;
            state <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ad9634_cfg_sequencer.sv
// Bench for ad9634_cfg_sequencer: behavioural SPI engine with a register file, plus an
// entry-by-entry outcome model; one verifying instance and one write-only instance.
module tb_ad9634_cfg_sequencer;

  localparam int MAX_RETRY = 2;
  localparam int TMO       = 200;
  localparam logic [6:0]  TBL_A [8] = '{7'h08, 7'h0D, 7'h14, 7'h15, 7'h16, 7'h17, 7'h18, 7'h30};
  localparam logic [15:0] TBL_D [8] = '{16'h0000, 16'h0000, 16'h0001, 16'h0000,
                                        16'h0000, 16'h0000, 16'h0004, 16'h0000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  bit   sel = 1'b0;
  logic busy_in = 1'b0;
  logic [15:0] dout_in = '0;

  logic st0, st1;
  logic [7:0]  addr0, addr1;
  logic [15:0] commd0, commd1, edata0, edata1;
  logic        send0, send1, busy0, busy1, done0, done1, err0, err1;
  logic [3:0]  eidx0, eidx1;

  assign st0 = start & ~sel;
  assign st1 = start & sel;

  ad9634_cfg_sequencer #(.NUM_REGS(8), .VERIFY(1), .SEND_HOLD(4), .TIMEOUT_CLKS(TMO),
                         .MAX_RETRY(MAX_RETRY)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(st0), .spi_busy_i(busy_in), .spi_dout_i(dout_in),
    .spi_addr_o(addr0), .spi_commd_o(commd0), .spi_send_o(send0), .busy_o(busy0),
    .done_o(done0), .err_o(err0), .err_idx_o(eidx0), .err_data_o(edata0));

  ad9634_cfg_sequencer #(.NUM_REGS(8), .VERIFY(0), .SEND_HOLD(4), .TIMEOUT_CLKS(TMO),
                         .MAX_RETRY(MAX_RETRY)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(st1), .spi_busy_i(busy_in), .spi_dout_i(dout_in),
    .spi_addr_o(addr1), .spi_commd_o(commd1), .spi_send_o(send1), .busy_o(busy1),
    .done_o(done1), .err_o(err1), .err_idx_o(eidx1), .err_data_o(edata1));

  logic [7:0]  m_addr;
  logic [15:0] m_commd, m_edata;
  logic        m_send, m_busy, m_done, m_err;
  logic [3:0]  m_eidx;
  assign m_addr  = sel ? addr1  : addr0;
  assign m_commd = sel ? commd1 : commd0;
  assign m_send  = sel ? send1  : send0;
  assign m_busy  = sel ? busy1  : busy0;
  assign m_done  = sel ? done1  : done0;
  assign m_err   = sel ? err1   : err0;
  assign m_eidx  = sel ? eidx1  : eidx0;
  assign m_edata = sel ? edata1 : edata0;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // SPI engine model state
  int rise_dly = 1, bsy_len = 1, ignore_n = 0;
  bit bad_addr = 1'b0;
  bit corrupt_q[$];
  bit flag_q[$];
  logic [7:0] log_q[$];
  int slen_q[$];
  logic [15:0] mem [128];
  int rphase = 0, rcnt = 0, slen = 0;
  logic send_prev = 1'b0;
  logic [7:0] cur_addr = '0;
  logic [15:0] cur_commd = '0, rv = '0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_in = 1'b0; dout_in = '0; rphase = 0; slen = 0; send_prev = 1'b0;
    end else begin
      if (m_send && !send_prev) begin
        log_q.push_back(m_addr);
        cur_addr = m_addr; cur_commd = m_commd; slen = 0;
        if (ignore_n > 0) ignore_n--;
        else begin rphase = 1; rcnt = rise_dly; end
      end
      if (m_send) slen++;
      else if (send_prev) slen_q.push_back(slen);
      send_prev = m_send;
      if (rphase == 1) begin
        if (rcnt == 0) begin busy_in = 1'b1; rcnt = bsy_len; rphase = 2; end
        else rcnt--;
      end else if (rphase == 2) begin
        if (rcnt == 0) begin
          busy_in = 1'b0; rphase = 0;
          if (cur_addr[7]) mem[cur_addr[6:0]] = cur_commd;
          else begin
            rv = mem[cur_addr[6:0]];
            if (bad_addr && cur_addr[6:0] == 7'h14) rv = 16'h0005;
            if (corrupt_q.size() > 0) begin
              if (corrupt_q.pop_front()) rv = rv ^ 16'h8000;
            end
            dout_in = rv;
          end
        end else rcnt--;
      end
    end
  end

  // Expected outcome, derived entry by entry from the retry rules
  logic [7:0] exp_q[$];
  bit e_done, e_err;
  logic [3:0] e_idx;
  logic [15:0] e_data;

  function automatic void model(input bit ver, input bit bad14, input bit norise);
    int fi;
    bit ok;
    logic [15:0] v;
    fi = 0; exp_q.delete();
    e_done = 0; e_err = 0; e_idx = '0; e_data = '0;
    for (int idx = 0; idx < 8; idx++) begin
      ok = 0;
      for (int a = 0; a <= MAX_RETRY; a++) begin
        exp_q.push_back({1'b1, TBL_A[idx]});
        if (norise) continue;
        if (!ver) begin ok = 1; break; end
        exp_q.push_back({1'b0, TBL_A[idx]});
        v = TBL_D[idx];
        if (bad14 && TBL_A[idx] == 7'h14) v = 16'h0005;
        if (fi < flag_q.size() && flag_q[fi]) v = v ^ 16'h8000;
        fi++;
        e_data = v;
        if (v == TBL_D[idx]) begin ok = 1; break; end
      end
      if (!ok) begin e_err = 1; e_idx = 4'(idx); return; end
    end
    e_done = 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (!(m_done || m_err) && n < 20000) begin @(negedge clk); n++; end
    check({name, "_end_timeout"}, 32'(n < 20000), 1);
  endtask

  task automatic run_cmp(input string name, input bit bad14, input bit norise);
    int bad;
    bad_addr = bad14; ignore_n = norise ? 1000 : 0;
    corrupt_q = flag_q; log_q.delete(); slen_q.delete();
    model(!sel, bad14, norise);
    pulse_start();
    wait_end(name);
    repeat (2) @(negedge clk);
    check({name, "_done"}, m_done, e_done);
    check({name, "_err"}, m_err, e_err);
    check({name, "_err_idx"}, m_eidx, e_idx);
    check({name, "_err_data"}, m_edata, e_data);
    check({name, "_busy"}, m_busy, 0);
    check({name, "_txn_count"}, log_q.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      if (log_q[i] !== exp_q[i]) bad++;
    check({name, "_txn_order"}, bad, 0);
  endtask

  typedef struct {
    bit    dut;
    int    rise;
    int    blen;
    bit    bad14;
    bit    norise;
    bit    x_done;
    logic [3:0] x_idx;
    logic [15:0] x_data;
    int    x_txn;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n, bad;
    vecs[0] = '{0, 2, 3, 0, 0, 1, 4'd0, 16'h0000, 16};
    vecs[1] = '{0, 0, 0, 0, 0, 1, 4'd0, 16'h0000, 16};
    vecs[2] = '{0, 3, 2, 1, 0, 0, 4'd2, 16'h0005, 10};
    vecs[3] = '{0, 1, 1, 0, 1, 0, 4'd0, 16'h0000, 3};
    vecs[4] = '{1, 5, 2, 0, 0, 1, 4'd0, 16'h0000, 8};
    vecs[5] = '{1, 0, 0, 0, 0, 1, 4'd0, 16'h0000, 8};
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);

    repeat (3) @(negedge clk);
    check("reset_outputs_dut0", {addr0, commd0, send0, busy0, done0, err0, eidx0, edata0} == '0, 1);
    check("reset_outputs_dut1", {addr1, commd1, send1, busy1, done1, err1, eidx1, edata1} == '0, 1);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_no_txn", log_q.size() + 32'(send0) + 32'(send1), 0);

    // Directed table: normal, fast engine, stuck read-back, dead engine, write-only
    for (int v = 0; v < 6; v++) begin
      sel = vecs[v].dut; rise_dly = vecs[v].rise; bsy_len = vecs[v].blen;
      flag_q.delete();
      run_cmp($sformatf("vec%0d", v), vecs[v].bad14, vecs[v].norise);
      check($sformatf("vec%0d_tbl_done", v), m_done, vecs[v].x_done);
      check($sformatf("vec%0d_tbl_idx", v), m_eidx, vecs[v].x_idx);
      check($sformatf("vec%0d_tbl_data", v), m_edata, vecs[v].x_data);
      check($sformatf("vec%0d_tbl_txn", v), log_q.size(), vecs[v].x_txn);
      if (vecs[v].norise) begin
        bad = 0;
        foreach (slen_q[i]) if (slen_q[i] != 4) bad++;
        check("norise_send_width", bad, 0);
      end
    end

    // Randomized engine timing and read corruption
    for (int r = 0; r < 12; r++) begin
      sel = (r % 4 == 3);
      rise_dly = $urandom_range(0, 7); bsy_len = $urandom_range(0, 6);
      flag_q.delete();
      for (int k = 0; k < 30; k++)
        flag_q.push_back((r % 2 == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) == 0));
      run_cmp($sformatf("rand%0d", r), 0, 0);
    end

    // Reset in WAIT_FALL of index 3
    sel = 0; rise_dly = 6; bsy_len = 12; ignore_n = 0; bad_addr = 0;
    flag_q.delete(); corrupt_q.delete(); log_q.delete();
    pulse_start();
    n = 0;
    while (!(log_q.size() >= 7 && busy_in) && n < 5000) begin @(negedge clk); n++; end
    check("rst_reach_idx3", 32'(n < 5000), 1);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check("rst_async_zero", {addr0, commd0, send0, busy0, done0, err0, eidx0, edata0} == '0, 1);
    @(negedge clk) rst_n = 1'b1;
    log_q.delete();
    repeat (15) @(negedge clk);
    check("rst_no_txn_without_start", log_q.size(), 0);
    rise_dly = 1; bsy_len = 1;
    pulse_start();
    wait_end("rst_rerun");
    check("rst_rerun_done", done0, 1);
    check("rst_rerun_first_addr", log_q.size() > 0 ? 32'(log_q[0]) : 32'hFFFF, 32'h88);
    check("rst_rerun_count", log_q.size(), 16);

    // start held high through DONE reruns the sequence
    log_q.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    wait_end("hold1");
    @(negedge clk);
    check("hold_done_cleared", {done0, busy0}, 2'b01);
    start = 1'b0;
    wait_end("hold2");
    check("hold_txn_count", log_q.size(), 32);
    check("hold_done", done0, 1);

    // start toggled while busy has no effect
    log_q.delete();
    pulse_start();
    for (int i = 0; i < 12; i++) @(negedge clk) start = ~start;
    start = 1'b0;
    wait_end("toggle");
    repeat (3) @(negedge clk);
    check("toggle_txn_count", log_q.size(), 16);
    check("toggle_done_err", {done0, err0}, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: actual=expired expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ad9634_cfg_sequencer.md
AD9634_CFG_SEQUENCER -- requirements
Module: ad9634_cfg_sequencer

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8: number of configuration table entries, range 1..16.
REQ-002 SHALL have parameter VERIFY, default 1: 1 = read back and compare each written register, 0 = write only.
REQ-003 SHALL have parameter SEND_HOLD, default 4: clk_i cycles spi_send_o stays high per transaction, minimum 3.
REQ-004 SHALL have parameter TIMEOUT_CLKS, default 4096: maximum clk_i cycles allowed for each of the busy-rise wait and the busy-fall wait.
REQ-005 SHALL have parameter MAX_RETRY, default 2: retries per entry after a mismatch or timeout.
REQ-006 SHALL have one clock, clk_i, and reset rst_n_i, which is asynchronous and active-low.
REQ-007 Ports, as name / direction / width / meaning:
- clk_i / in / 1 / clock
- rst_n_i / in / 1 / async active-low reset
- start_i / in / 1 / start sequence; level, sampled in IDLE/DONE/ERR
- spi_busy_i / in / 1 / SPI engine busy
- spi_dout_i / in / 16 / SPI engine read data
- spi_addr_o / out / 8 / to SPI ADDR; bit7 = 1 write, 0 read
- spi_commd_o / out / 16 / to SPI COMMD, write data
- spi_send_o / out / 1 / transaction request to the SPI engine
- busy_o / out / 1 / sequence running
- done_o / out / 1 / all entries written/verified
- err_o / out / 1 / sequence aborted
- err_idx_o / out / 4 / table index of the failing entry
- err_data_o / out / 16 / last read-back value of the failing entry

Function
REQ-008 SHALL hold an internal constant table; entry i is {7-bit address, 16-bit data}, i = 0..NUM_REGS-1.
REQ-009 Default table contents SHALL be: {0x08,0x0000}, {0x0D,0x0000}, {0x14,0x0001}, {0x15,0x0000}, {0x16,0x0000}, {0x17,0x0000}, {0x18,0x0004}, {0x30,0x0000}.
REQ-010 States SHALL be IDLE, LOAD, SEND, WAIT_RISE, WAIT_FALL, CHECK, NEXT, DONE, ERR.
REQ-011 In IDLE, DONE or ERR with start_i = 1, the block SHALL do all of the following in one transition to LOAD:
- clear done_o, err_o, err_idx_o, err_data_o
- set index = 0, retry = 0, phase = WRITE
- set busy_o = 1
REQ-012 LOAD SHALL drive the SPI outputs for one cycle, then go to SEND:
- WRITE phase: spi_addr_o = {1, addr} and spi_commd_o = data
- READ phase: spi_addr_o = {0, addr} and spi_commd_o = 0x0000
REQ-013 spi_addr_o and spi_commd_o SHALL remain stable from LOAD until leaving WAIT_FALL.
REQ-014 SEND SHALL hold spi_send_o = 1 for exactly SEND_HOLD cycles, then deassert it and enter WAIT_RISE.
REQ-015 WAIT_RISE SHALL exit on spi_busy_i = 1 to WAIT_FALL; a rise already seen during SEND SHALL also count.
REQ-016 WAIT_FALL SHALL exit on spi_busy_i = 0 to CHECK.
REQ-017 The timeout counter SHALL reset on entry to WAIT_RISE and to WAIT_FALL; reaching TIMEOUT_CLKS in either state SHALL be a failure.
REQ-018 CHECK, WRITE phase: VERIFY = 1 -> phase = READ, go to LOAD; VERIFY = 0 -> go to NEXT.
REQ-019 CHECK, READ phase: sample spi_dout_i one cycle after busy falls and store it in err_data_o.
- match to entry data -> NEXT
- mismatch -> failure
REQ-020 On failure with retry < MAX_RETRY: retry += 1, phase = WRITE, go to LOAD. Otherwise: err_idx_o = index, err_o = 1, busy_o = 0, go to ERR.
REQ-021 NEXT SHALL clear retry and set phase = WRITE.
- index = NUM_REGS-1 -> DONE with done_o = 1, busy_o = 0
- otherwise -> index += 1, go to LOAD
REQ-022 start_i SHALL be ignored while busy_o = 1.
REQ-023 done_o and err_o SHALL be mutually exclusive and SHALL hold until the next start or reset.

Reset
REQ-024 rst_n_i = 0 SHALL, asynchronously, set state = IDLE and zero every output, index, retry and counter, including mid-transaction.
REQ-025 After rst_n_i deasserts, no transaction SHALL begin until start_i = 1.

Verification
REQ-026 VERIFY = 1, SPI model echoing written data, start pulse -> 16 transactions, addr bit7 alternating 1/0, done_o = 1, err_o = 0.
REQ-027 Model returns 0x0005 for address 0x14 on every read -> 3 write/read attempts at index 2, err_o = 1, err_idx_o = 2, err_data_o = 0x0005.
REQ-028 spi_busy_i never rises on the first transaction -> spi_send_o high exactly SEND_HOLD cycles per attempt, 3 attempts, err_o = 1, err_idx_o = 0.
REQ-029 VERIFY = 0 -> 8 writes, addresses 0x88, 0x8D, 0x94, 0x95, 0x96, 0x97, 0x98, 0xB0 in order, done_o = 1.
REQ-030 rst_n_i asserted during WAIT_FALL of index 3 -> all outputs 0 immediately; a new start restarts at index 0.
REQ-031 start_i held high through DONE -> sequence reruns with done_o cleared; start_i toggled while busy_o = 1 -> no effect.
